// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and its neighbouring pipeline stages.
// Holds the stage encoding and the fetch FSM state encoding so decode and
// execute agree on what stage_o means.
package fetch_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      STAGE_FETCH     = 3'd0,
      STAGE_DECODE    = 3'd1,
      STAGE_EXECUTE   = 3'd2,
      STAGE_MEMORY    = 3'd3,
      STAGE_WRITEBACK = 3'd4
   } stage_e;

   typedef enum logic [1:0] {
      FSM_REQ  = 2'd0,
      FSM_HOLD = 2'd1,
      FSM_HALT = 2'd2
   } fsm_state_e;

   // Stage sequence; WRITEBACK wraps back to FETCH, unused codes recover to FETCH.
   function automatic stage_e next_stage(input stage_e cur);
      case (cur)
         STAGE_FETCH:     return STAGE_DECODE;
         STAGE_DECODE:    return STAGE_EXECUTE;
         STAGE_EXECUTE:   return STAGE_MEMORY;
         STAGE_MEMORY:    return STAGE_WRITEBACK;
         default:         return STAGE_FETCH;
      endcase
   endfunction

   // Word-align an address by clearing the byte offset.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   // True when the address has a zero byte offset.
   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr & 32'h0000_0003) == 32'h0;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ack_i;
   logic [XLEN-1:0] imem_data_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_data_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_data_i
   );

endinterface

// File: rtl/fetch_stage_ctr.sv
// Pipeline stage counter for the fetch unit: steps FETCH..WRITEBACK when
// advance is high, holds otherwise, and returns to FETCH on a synchronous clear.
module fetch_stage_ctr
   import fetch_unit_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   clear,
   input  logic   advance,
   output stage_e stage
);

   // Stage register: reset/clear take priority over advancing.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         stage <= STAGE_FETCH;
      end else if (advance) begin
         stage <= next_stage(stage);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch unit: requests an instruction, holds it in ir_o while the
// stage counter walks DECODE..WRITEBACK, then retires it and moves the PC on.
// Optional feature macro: FETCH_ALIGN_CHECK_EN enables the misaligned
// redirect-target fault and the HALT state; without it the target is
// silently word-aligned and fault_o is tied low.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
)
(
   input  logic        clk,
   input  logic        reset,
   fetch_unit_if.master imem,
   output logic [31:0] ir_o,
   output logic [2:0]  stage_o,
   output logic [31:0] pc_o,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instret_o,
   output logic        fault_o
);

   fsm_state_e  state_q;
   fsm_state_e  state_d;
   stage_e      stage;
   logic        req;
   logic        stage_adv;
   logic        stage_clr;
   logic        capture;
   logic        retire;
   logic [31:0] pc_next;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        take_fault;
   logic        fault_q;
`endif

   fetch_stage_ctr u_stage_ctr (
      .clk     (clk),
      .reset   (reset),
      .clear   (stage_clr),
      .advance (stage_adv),
      .stage   (stage)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FSM_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode: capture on ack, walk stages, retire in WRITEBACK.
   always_comb begin
      state_d   = state_q;
      req       = 1'b0;
      stage_adv = 1'b0;
      stage_clr = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      take_fault = 1'b0;
`endif
      case (state_q)
         FSM_REQ: begin
            req = 1'b1;
            if (imem.imem_ack_i) begin
               capture   = 1'b1;
               stage_adv = 1'b1;
               state_d   = FSM_HOLD;
            end
         end
         FSM_HOLD: begin
            if (!stall_i) begin
               if (stage == STAGE_WRITEBACK) begin
`ifdef FETCH_ALIGN_CHECK_EN
                  if (redirect_i && !is_word_aligned(redirect_pc_i)) begin
                     take_fault = 1'b1;
                     state_d    = FSM_HALT;
                  end else begin
                     retire    = 1'b1;
                     stage_clr = 1'b1;
                     state_d   = FSM_REQ;
                  end
`else
                  retire    = 1'b1;
                  stage_clr = 1'b1;
                  state_d   = FSM_REQ;
`endif
               end else begin
                  stage_adv = 1'b1;
               end
            end
         end
         FSM_HALT: begin
            state_d = FSM_HALT;
         end
         default: begin
            state_d = FSM_REQ;
         end
      endcase
   end

   // Redirect target is word-aligned; a misaligned one never reaches here when the checker faults.
   always_comb begin
      pc_next = redirect_i ? align_word(redirect_pc_i) : (pc_o + PC_STEP);
   end

   // Architectural registers: instruction capture, PC update and retire count.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_o      <= RESET_PC;
         ir_o      <= 32'h0;
         instret_o <= 32'h0;
      end else begin
         if (capture) begin
            ir_o <= imem.imem_data_i;
         end
         if (retire) begin
            pc_o      <= pc_next;
            instret_o <= instret_o + 32'd1;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky misaligned-target fault, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (take_fault) begin
         fault_q <= 1'b1;
      end
   end

   assign fault_o = fault_q;
`else
   assign fault_o = 1'b0;
`endif

   // Request is masked while reset is asserted so it rises only after release.
   assign imem.imem_req_o  = req && !reset;
   assign imem.imem_addr_o = pc_o;
   assign stage_o          = stage;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A second instance with
// RESET_PC at the top of the address space runs in lockstep for the wrap case.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        ack;
   logic [31:0] data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic [31:0] ir0, pc0, instret0, ir1, pc1, instret1;
   logic [2:0]  stage0, stage1;
   logic        fault0, fault1;

   int checks;
   int failures;

   fetch_unit_if bus0 ();
   fetch_unit_if bus1 ();

   assign bus0.imem_ack_i  = ack;
   assign bus0.imem_data_i = data;
   assign bus1.imem_ack_i  = ack;
   assign bus1.imem_data_i = data;

   fetch_unit dut0 (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus0),
      .ir_o          (ir0),
      .stage_o       (stage0),
      .pc_o          (pc0),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instret_o     (instret0),
      .fault_o       (fault0)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk           (clk),
      .reset         (reset),
      .imem          (bus1),
      .ir_o          (ir1),
      .stage_o       (stage1),
      .pc_o          (pc1),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .instret_o     (instret1),
      .fault_o       (fault1)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      ack         = 1'b0;
      data        = 32'h0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b1;
      tick();
      checks++;
      if (bus0.imem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_req: got %b expected 0", bus0.imem_req_o);
      end
      checks++;
      if (pc0 !== 32'h0 || ir0 !== 32'h0 || stage0 !== 3'd0 || instret0 !== 32'h0 || fault0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: pc=%h ir=%h stage=%0d instret=%0d fault=%b expected all zero", pc0, ir0, stage0, instret0, fault0);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus0.imem_req_o !== 1'b1 || bus0.imem_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_release_req: req=%b addr=%h expected 1/00000000", bus0.imem_req_o, bus0.imem_addr_o);
      end
   endtask

   task automatic test_basic();
      logic [2:0] exp_stage;
      tick();
      ack  = 1'b1;
      data = 32'h0010_0093;
      tick();
      checks++;
      if (ir0 !== 32'h0010_0093 || pc0 !== 32'h0 || stage0 !== 3'd1 || bus0.imem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_capture: ir=%h pc=%h stage=%0d req=%b expected 00100093/0/1/0", ir0, pc0, stage0, bus0.imem_req_o);
      end
      data = 32'hDEAD_BEEF;
      for (int s = 2; s <= 4; s++) begin
         if (s == 4) ack = 1'b0;
         tick();
         exp_stage = 3'(s);
         checks++;
         if (stage0 !== exp_stage || ir0 !== 32'h0010_0093) begin
            failures++;
            $display("FAIL basic_stage%0d: stage=%0d ir=%h expected %0d/00100093", s, stage0, ir0, exp_stage);
         end
      end
      tick();
      checks++;
      if (stage0 !== 3'd0 || pc0 !== 32'h4 || instret0 !== 32'd1 || bus0.imem_req_o !== 1'b1 || bus0.imem_addr_o !== 32'h4) begin
         failures++;
         $display("FAIL basic_retire: stage=%0d pc=%h instret=%0d req=%b addr=%h expected 0/4/1/1/4", stage0, pc0, instret0, bus0.imem_req_o, bus0.imem_addr_o);
      end
   endtask

   task automatic test_wait();
      int n;
      ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus0.imem_req_o !== 1'b1 || bus0.imem_addr_o !== 32'h4 || ir0 !== 32'h0010_0093) begin
            failures++;
            $display("FAIL wait_hold%0d: req=%b addr=%h ir=%h expected 1/4/00100093", i, bus0.imem_req_o, bus0.imem_addr_o, ir0);
         end
      end
      ack  = 1'b1;
      data = 32'h0020_0113;
      tick();
      ack = 1'b0;
      checks++;
      if (ir0 !== 32'h0020_0113) begin
         failures++;
         $display("FAIL wait_capture: ir=%h expected 00200113", ir0);
      end
      n = 0;
      while (stage0 !== 3'd0 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n != 4 || pc0 !== 32'h8 || instret0 !== 32'd2) begin
         failures++;
         $display("FAIL wait_retire: cycles=%0d pc=%h instret=%0d expected 4/8/2", n, pc0, instret0);
      end
   endtask

   task automatic test_stall();
      int n;
      ack  = 1'b1;
      data = 32'h0030_0193;
      tick();
      ack = 1'b0;
      n = 1;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n++;
         checks++;
         if (stage0 !== 3'd2) begin
            failures++;
            $display("FAIL stall_hold%0d: stage=%0d expected 2", i, stage0);
         end
      end
      stall = 1'b0;
      while (stage0 !== 3'd0 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (n != 7 || pc0 !== 32'hC || instret0 !== 32'd3) begin
         failures++;
         $display("FAIL stall_retire: cycles=%0d pc=%h instret=%0d expected 7/c/3", n, pc0, instret0);
      end
   endtask

   task automatic test_redirect();
      // Pulse only in MEMORY: ignored, sequential PC.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      checks++;
      if (stage0 !== 3'd4 || pc0 !== 32'hC) begin
         failures++;
         $display("FAIL redir_pulse_mem: stage=%0d pc=%h expected 4/c", stage0, pc0);
      end
      tick();
      checks++;
      if (pc0 !== 32'h10 || instret0 !== 32'd4) begin
         failures++;
         $display("FAIL redir_pulse_ignored: pc=%h instret=%0d expected 10/4", pc0, instret0);
      end
      // Raised in MEMORY and held through WRITEBACK: taken.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      redirect = 1'b1;
      tick();
      checks++;
      if (pc0 !== 32'h10) begin
         failures++;
         $display("FAIL redir_early: pc=%h expected 10", pc0);
      end
      tick();
      redirect = 1'b0;
      checks++;
      if (pc0 !== 32'h100 || instret0 !== 32'd5 || stage0 !== 3'd0) begin
         failures++;
         $display("FAIL redir_taken: pc=%h instret=%0d stage=%0d expected 100/5/0", pc0, instret0, stage0);
      end
      // Stall in WRITEBACK defers the redirect.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      tick();
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      checks++;
      if (stage0 !== 3'd4 || pc0 !== 32'h100) begin
         failures++;
         $display("FAIL redir_stalled: stage=%0d pc=%h expected 4/100", stage0, pc0);
      end
      stall = 1'b0;
      tick();
      redirect = 1'b0;
      checks++;
      if (pc0 !== 32'h200 || instret0 !== 32'd6) begin
         failures++;
         $display("FAIL redir_deferred: pc=%h instret=%0d expected 200/6", pc0, instret0);
      end
   endtask

   task automatic test_align();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      tick();
      redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      checks++;
      if (fault0 !== 1'b1 || pc0 !== 32'h200 || instret0 !== 32'd6 || bus0.imem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL align_fault: fault=%b pc=%h instret=%0d req=%b expected 1/200/6/0", fault0, pc0, instret0, bus0.imem_req_o);
      end
      ack = 1'b1;
      tick();
      tick();
      tick();
      ack = 1'b0;
      checks++;
      if (bus0.imem_req_o !== 1'b0 || stage0 !== 3'd4 || pc0 !== 32'h200 || fault0 !== 1'b1) begin
         failures++;
         $display("FAIL align_halt: req=%b stage=%0d pc=%h fault=%b expected 0/4/200/1", bus0.imem_req_o, stage0, pc0, fault0);
      end
`else
      checks++;
      if (fault0 !== 1'b0 || pc0 !== 32'h100 || instret0 !== 32'd7 || bus0.imem_req_o !== 1'b1) begin
         failures++;
         $display("FAIL align_forced: fault=%b pc=%h instret=%0d req=%b expected 0/100/7/1", fault0, pc0, instret0, bus0.imem_req_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      ack  = 1'b1;
      data = 32'h0040_0213;
      tick();
      ack = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (instret0 !== 32'd0 || ir0 !== 32'h0 || stage0 !== 3'd0 || pc0 !== 32'h0 || bus0.imem_req_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: instret=%0d ir=%h stage=%0d pc=%h req=%b expected 0/0/0/0/1", instret0, ir0, stage0, pc0, bus0.imem_req_o);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++;
      if (bus1.imem_addr_o !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_start: addr=%h expected fffffffc", bus1.imem_addr_o);
      end
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (pc1 !== 32'h0 || instret1 !== 32'd1 || stage1 !== 3'd0) begin
         failures++;
         $display("FAIL wrap_pc: pc=%h instret=%0d stage=%0d expected 0/1/0", pc1, instret1, stage1);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_wait();
      test_stall();
      test_redirect();
      test_align();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
